// File: rtl/mem_stage.sv
// RV32I memory-access stage: load/store over a req/ready handshake.
// Optional misalignment trap under `MISALIGN_TRAP_EN`.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd_in,
  input  logic        wb_en_in,
  output logic        wb_en,
  output logic [4:0]  rd,
  output logic [31:0] result,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        ld_q;
  logic        wben_q;
  logic        mis_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        mem_op;
  logic        is_st;
  logic        sz_b;
  logic        sz_h;
  logic        mis_d;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign mem_op = valid & (mem_rd | mem_wr);
  assign is_st  = mem_wr & ~mem_rd;
  assign sz_b   = (funct3 == 3'b000) | (mem_rd & (funct3 == 3'b100));
  assign sz_h   = (funct3 == 3'b001) | (mem_rd & (funct3 == 3'b101));

`ifdef MISALIGN_TRAP_EN
  assign mis_d = sz_h ? addr[0] : (~sz_b & (|addr[1:0]));
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    strb_d  = 4'b1111;
    wdata_d = store_data;
    if (sz_b) begin
      strb_d  = 4'b0001 << addr[1:0];
      wdata_d = {4{store_data[7:0]}};
    end else if (sz_h) begin
      strb_d  = 4'b0011 << {addr[1], 1'b0};
      wdata_d = {2{store_data[15:0]}};
    end
  end

  assign shifted = rdata_q >> {lane_q, 3'b000};
  assign ld_b    = shifted[7:0];
  assign ld_h    = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    result = alu_result;
    rd     = rd_in;
    wb_en  = valid & wb_en_in & ~mem_op;
    stall  = mem_op;
    unique case (state_q)
      WAIT: begin
        stall  = 1'b1;
        wb_en  = 1'b0;
        rd     = rd_q;
        result = ld_data;
      end
      DONE: begin
        stall  = 1'b0;
        wb_en  = ld_q & wben_q & ~mis_q;
        rd     = rd_q;
        result = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      wben_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= 5'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            ld_q   <= mem_rd;
            wben_q <= wb_en_in;
            rd_q   <= rd_in;
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            if (mis_d) begin
              mis_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= is_st;
              addr_q  <= {addr[31:2], 2'b00};
              wdata_q <= wdata_d;
              wstrb_q <= is_st ? strb_d : 4'd0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            rdata_q <= dmem_rdata;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against an arithmetic reference model.
// Misalignment expectations follow `MISALIGN_TRAP_EN`.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, alu_result;
  logic [4:0]  rd_in;
  logic        wb_en_in;
  logic        wb_en;
  logic [4:0]  rd;
  logic [31:0] result;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .alu_result(alu_result), .rd_in(rd_in),
    .wb_en_in(wb_en_in), .wb_en(wb_en), .rd(rd),
    .result(result), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .misalign_err(misalign_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: access-size class from the instruction fields
  function automatic int size_of(input logic ld, input logic [2:0] f3);
    if (f3 == 3'b000 || (ld && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (ld && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic bit misal(input logic ld, input logic [2:0] f3,
                               input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    int sz = size_of(ld, f3);
    return (sz > 1) && ((a % sz) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] v;
    int lane = a % 4;
    int hl = (a / 2) % 2;
    case (f3)
      3'b000, 3'b100: begin
        v = (d >> (8 * lane)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (d >> (16 * hl)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3,
                                          input logic [31:0] a);
    int sz = size_of(1'b0, f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3,
                                            input logic [31:0] sd);
    int sz = size_of(1'b0, f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic go_idle();
    valid      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // Entered at posedge+1; leaves at posedge+1 after DONE.
  task automatic mem_op(input logic ld_i, input logic st_i,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat,
                        input int k, input logic [4:0] r,
                        input logic we_in);
    logic ld = ld_i;
    logic st = st_i & ~ld_i;
    bit   mis = misal(ld, f3, a);
    valid = 1'b1; mem_rd = ld_i; mem_wr = st_i;
    funct3 = f3; addr = a; store_data = sd;
    rd_in = r; wb_en_in = we_in;
    alu_result = $urandom;
    dmem_ready = 1'($urandom);
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_wben", 32'(wb_en), 32'd0);
    check("idle_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    if (!mis) begin
      for (int i = 1; i <= k; i++) begin
        dmem_ready = (i == k);
        dmem_rdata = (i == k) ? rdat : $urandom;
        @(negedge clk);
        check("wait_stall", 32'(stall), 32'd1);
        check("wait_wben", 32'(wb_en), 32'd0);
        check("wait_req", 32'(dmem_req), 32'd1);
        check("wait_addr", dmem_addr, a & 32'hFFFF_FFFC);
        check("wait_we", 32'(dmem_we), 32'(st));
        check("wait_strb", 32'(dmem_wstrb),
              st ? 32'(exp_strb(f3, a)) : 32'd0);
        if (st) check("wait_wdata", dmem_wdata, exp_wdata(f3, sd));
        @(posedge clk); #1;
      end
    end
    dmem_ready = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall), 32'd0);
    check("done_req", 32'(dmem_req), 32'd0);
    check("done_mis", 32'(misalign_err), 32'(mis));
    check("done_wben", 32'(wb_en), 32'(ld & we_in & ~mis));
    if (ld && !mis) begin
      check("done_result", result, exp_load(f3, a, rdat));
      check("done_rd", 32'(rd), 32'(r));
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  task automatic alu_op(input logic v, input logic [31:0] res,
                        input logic [4:0] r, input logic we_in);
    valid = v;
    mem_rd = v ? 1'b0 : 1'($urandom);
    mem_wr = v ? 1'b0 : 1'($urandom);
    alu_result = res; rd_in = r; wb_en_in = we_in;
    dmem_ready = 1'($urandom);
    @(negedge clk);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);
    check("alu_wben", 32'(wb_en), 32'(v & we_in));
    if (v) begin
      check("alu_result", result, res);
      check("alu_rd", 32'(rd), 32'(r));
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    go_idle();
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    alu_result = 32'd0; rd_in = 5'd0; wb_en_in = 1'b0;
    dmem_rdata = 32'd0;
    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_strb", 32'(dmem_wstrb), 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op(1'b1, 32'h1234, 5'd5, 1'b1);
    mem_op(1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 1, 5'd7, 1);
    mem_op(1, 0, 3'b100, 32'h103, 0, 32'h80FF_0000, 1, 5'd7, 1);
    mem_op(0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 1, 5'd0, 1);
    mem_op(1, 0, 3'b010, 32'h40, 0, 32'hDEAD_BEEF, 6, 5'd9, 1);
    mem_op(1, 0, 3'b010, 32'h101, 0, 32'h1357_9BDF, 1, 5'd3, 1);
    mem_op(1, 1, 3'b001, 32'h2, 0, 32'h8001_7FFF, 2, 5'd4, 1);

    // reset pulse while an access is outstanding
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    funct3 = 3'b010; addr = 32'h300; rd_in = 5'd6; wb_en_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_req_before", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_req_async", 32'(dmem_req), 32'd0);
    go_idle();
    @(posedge clk); #2;
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_wben", 32'(wb_en), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_late_wben", 32'(wb_en), 32'd0);
    check("rstw_late_req", 32'(dmem_req), 32'd0);
    check("rstw_late_mis", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    go_idle();

    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 3);
      logic [2:0] f3 = 3'($urandom);
      case (kind)
        0: alu_op(1'b0, $urandom, 5'($urandom), 1'($urandom));
        1: alu_op(1'b1, $urandom, 5'($urandom), 1'($urandom));
        2: mem_op(1, 1'($urandom_range(0, 3) == 0), f3, $urandom,
                  $urandom, $urandom, $urandom_range(1, 4),
                  5'($urandom), 1'($urandom));
        default: mem_op(0, 1, f3, $urandom, $urandom, $urandom,
                        $urandom_range(1, 4), 5'($urandom),
                        1'($urandom));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
